// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
//
// Instruction fetch unit with a prefetch FIFO. It fetches sequential
// instructions over a valid/ready memory interface with at most one request
// in flight. Fetched words are buffered together with their PCs in a
// DEPTH-entry FIFO and handed to the IDU over a valid/ready handshake.
// A redirect from the EXU flushes the FIFO and discards any stale response.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous active-low reset
//   jump_en     redirect request from EXU
//   jump_addr   redirect target
//   req_valid   fetch request valid
//   req_ready   memory accepts request
//   req_addr    fetch address
//   resp_valid  memory response valid (always accepted)
//   resp_data   fetched instruction
//   inst_valid  FIFO head valid toward IDU
//   inst_ready  IDU accepts head
//   inst_o      head instruction
//   PCout       head PC
//   inst_fault  head entry is a misalignment fault
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   When defined, a redirect to an address not aligned to PC_STEP issues no
//   fetch; it queues a single fault entry {inst=0, PC=jump_addr, fault=1} and
//   fetch stalls until the next redirect. When undefined, inst_fault is 0.
// ---------------------------------------------------------------------------
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] PCout,
    output logic              inst_fault
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_after;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              drop;
    logic              resp_live;
    logic              enq;
    logic              deq;
    logic              issue;
    logic              jump_misaligned;
    logic              stalled;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

`ifdef IFU_MISALIGN_CHECK_EN
    logic              halt;
    logic              fault_mem [DEPTH];

    assign jump_misaligned = (jump_addr % STEP_C) != '0;
    assign stalled         = halt;
    assign inst_fault      = inst_valid && fault_mem[rd_ptr];
`else
    assign jump_misaligned = 1'b0;
    assign stalled         = 1'b0;
    assign inst_fault      = 1'b0;
`endif

    assign inst_valid = (count != '0);
    assign inst_o     = inst_mem[rd_ptr];
    assign PCout      = pc_mem[rd_ptr];

    // Fetch control. A new request is launched straight out of IDLE, or in the
    // same cycle a response lands in WAIT, so a 1-cycle memory sustains one
    // instruction per cycle. Launching is suppressed during a redirect because
    // fetch_pc is still the stale sequential address in that cycle; the
    // redirect target is fetched from IDLE next cycle. A request already
    // presented in REQ is never retracted and always uses the captured req_pc.
    always_comb begin
        state_nxt = state;
        deq       = inst_valid && inst_ready;
        resp_live = (state == WAIT) && resp_valid;
        enq       = resp_live && !drop && !jump_en;
        cnt_after = count + CNT_W'(enq) - CNT_W'(deq);
        issue     = rst && !jump_en && !stalled &&
                    (((state == IDLE) && (count < DEPTH_C)) ||
                     (resp_live && (cnt_after < DEPTH_C)));
        req_valid = (state == REQ) || issue;
        req_addr  = (state == REQ) ? req_pc : fetch_pc;

        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = req_ready ? WAIT : REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    if (issue) begin
                        state_nxt = req_ready ? WAIT : REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, PC and FIFO bookkeeping. fetch_pc advances when a request is
    // launched, so it always names the next address to fetch; this lets a
    // redirect overwrite it freely while an older request is still pending.
    // Any response arriving in WAIT consumes the drop flag, so at most one
    // response is ever discarded per redirect burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (issue) begin
                req_pc <= fetch_pc;
            end

            if (jump_en) begin
                fetch_pc <= jump_addr;
            end else if (issue) begin
                fetch_pc <= fetch_pc + STEP_C;
            end

            if (resp_live) begin
                drop <= 1'b0;
            end else if (jump_en && ((state == REQ) || (state == WAIT))) begin
                drop <= 1'b1;
            end

            if (jump_en) begin
                rd_ptr <= '0;
                wr_ptr <= jump_misaligned ? PTR_W'(1) : '0;
                count  <= jump_misaligned ? CNT_W'(1) : '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= cnt_after;
            end
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Fetch stall after a misaligned redirect; only another redirect lifts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halt <= 1'b0;
        end else if (jump_en) begin
            halt <= jump_misaligned;
        end
    end
`endif

    // FIFO storage. A misaligned redirect lands its fault entry in slot 0,
    // matching the pointer reset done by the flush in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (jump_en && jump_misaligned) begin
                inst_mem[0]  <= '0;
                pc_mem[0]    <= jump_addr;
`ifdef IFU_MISALIGN_CHECK_EN
                fault_mem[0] <= 1'b1;
`endif
            end else if (enq) begin
                inst_mem[wr_ptr]  <= resp_data;
                pc_mem[wr_ptr]    <= req_pc;
`ifdef IFU_MISALIGN_CHECK_EN
                fault_mem[wr_ptr] <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch
//
// Self-checking bench for ifu_prefetch. The bench plays the memory (random
// ready and 1..3 cycle latency, one request in flight) and the IDU. The
// reference model only knows program order: after reset or a redirect the
// IDU must see consecutive PCs starting at the reset/redirect address, each
// paired with the memory word for that PC, with nothing stale in between.
// Directed phases pin the model with literal expectations.
// Optional macro: IFU_MISALIGN_CHECK_EN (adds misaligned-redirect checks).
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;

    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    localparam int MODE_ONE  = 0;
    localparam int MODE_ZERO = 1;
    localparam int MODE_RAND = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              jump_en = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid = 1'b0;
    logic [INST_W-1:0] resp_data = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] PCout;
    logic              inst_fault;

    ifu_prefetch #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_o     (inst_o),
        .PCout      (PCout),
        .inst_fault (inst_fault)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Stimulus configuration.
    bit rstDrive = 1'b0;
    int rrMode   = MODE_ONE;
    int irMode   = MODE_ONE;
    int latMin   = 1;
    int latMax   = 1;

    // Memory model state.
    bit          memPend = 1'b0;
    int          memWait = 0;
    logic [31:0] memAddr = '0;

    // Program-order model state.
    logic [31:0] expPc       = RESET_PC;
    bit          expFault    = 1'b0;
    bit          mHalt       = 1'b0;
    bit          fetchHalted = 1'b0;
    bit          haltAllow   = 1'b0;
    bit          prevJump    = 1'b0;
    bit          prevJumpMis = 1'b0;
    bit          prevReqHeld = 1'b0;
    logic [31:0] prevReqAddr = '0;
    int          idleRun     = 0;
    int          rstCycles   = 0;

    logic [31:0] hsLog[$];
    logic [31:0] dlvLog[$];

    // Memory contents as a pure function of address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model for the cycle just driven, then
    // advance the memory and program-order models across the coming edge.
    task automatic checkOutput();
        bit hs;
        bit deq;
        bit mis;
        hs  = req_valid && req_ready;
        deq = inst_valid && inst_ready;
        if (!rst) begin
            if (rstCycles >= 1) begin
                chk("reset_req_valid", req_valid, 0);
                chk("reset_inst_valid", inst_valid, 0);
                chk("reset_inst_fault", inst_fault, 0);
            end
            rstCycles++;
            expPc       = RESET_PC;
            expFault    = 1'b0;
            mHalt       = 1'b0;
            fetchHalted = 1'b0;
            haltAllow   = 1'b0;
            memPend     = 1'b0;
            prevJump    = 1'b0;
            prevReqHeld = 1'b0;
            idleRun     = 0;
        end else begin
            rstCycles = 0;

            if (prevReqHeld) begin
                chk("req_hold_valid", req_valid, 1);
                chk("req_hold_addr", req_addr, prevReqAddr);
            end

            if (prevJump) begin
                if (prevJumpMis) begin
                    chk("fault_entry_valid", inst_valid, 1);
                    chk("fault_entry_flag", inst_fault, 1);
                end else begin
                    chk("flush_empty", inst_valid, 0);
                end
            end

            if (deq) begin
                dlvLog.push_back(PCout);
                idleRun = 0;
                if (mHalt) begin
                    chk("deliver_after_fault", deq, 0);
                end else if (expFault) begin
                    chk("fault_pc", PCout, expPc);
                    chk("fault_inst", inst_o, 0);
                    chk("fault_flag", inst_fault, 1);
                    mHalt = 1'b1;
                end else begin
                    chk("deliver_pc", PCout, expPc);
                    chk("deliver_inst", inst_o, memWord(expPc));
                    chk("deliver_fault", inst_fault, 0);
                    expPc = expPc + PC_STEP;
                end
            end else if (inst_ready && !mHalt) begin
                idleRun++;
                if (idleRun > 60) begin
                    chk("progress_timeout", idleRun, 0);
                    idleRun = 0;
                end
            end

            if (hs) begin
                chk("one_in_flight", memPend && !resp_valid, 0);
                if (fetchHalted) begin
                    chk("req_while_halted", haltAllow, 1);
                    haltAllow = 1'b0;
                end
                hsLog.push_back(req_addr);
            end

            if (resp_valid) begin
                memPend = 1'b0;
            end else if (memPend) begin
                memWait--;
            end
            if (hs) begin
                memPend = 1'b1;
                memAddr = req_addr;
                memWait = $urandom_range(latMin, latMax) - 1;
            end

            prevReqHeld = req_valid && !req_ready;
            prevReqAddr = req_addr;
            prevJump    = jump_en;
            if (jump_en) begin
`ifdef IFU_MISALIGN_CHECK_EN
                mis = (jump_addr % PC_STEP) != 0;
`else
                mis = 1'b0;
`endif
                prevJumpMis = mis;
                expPc       = jump_addr;
                expFault    = mis;
                mHalt       = 1'b0;
                fetchHalted = mis;
                haltAllow   = mis && req_valid && !req_ready;
                idleRun     = 0;
            end
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then check.
    task automatic applyStimulus(input bit jmp, input logic [31:0] ja);
        @(negedge clk);
        rst        = rstDrive;
        jump_en    = jmp && rstDrive;
        jump_addr  = ja;
        req_ready  = (rrMode == MODE_ONE)  ? 1'b1 :
                     (rrMode == MODE_ZERO) ? 1'b0 : ($urandom_range(0, 3) != 0);
        inst_ready = (irMode == MODE_ONE)  ? 1'b1 :
                     (irMode == MODE_ZERO) ? 1'b0 : ($urandom_range(0, 1) != 0);
        resp_valid = rstDrive && memPend && (memWait == 0);
        resp_data  = resp_valid ? memWord(memAddr) : $urandom;
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rstDrive = 1'b0;
        repeat (3) applyStimulus(1'b0, '0);
        rstDrive = 1'b1;
        hsLog.delete();
        dlvLog.delete();
    endtask

    task automatic runIdle(input int n);
        repeat (n) applyStimulus(1'b0, '0);
    endtask

    initial begin
        int hsBefore;
        logic [31:0] ja;

        // Sequential stream, 1-cycle memory, IDU always ready.
        rrMode = MODE_ONE; irMode = MODE_ONE; latMin = 1; latMax = 1;
        doReset();
        applyStimulus(1'b0, '0);
        chk("A_c0_req_valid", req_valid, 1);
        chk("A_c0_req_addr", req_addr, 32'h8000_0000);
        chk("A_c0_inst_valid", inst_valid, 0);
        applyStimulus(1'b0, '0);
        chk("A_c1_req_addr", req_addr, 32'h8000_0004);
        chk("A_c1_inst_valid", inst_valid, 0);
        applyStimulus(1'b0, '0);
        chk("A_c2_req_addr", req_addr, 32'h8000_0008);
        chk("A_c2_inst_valid", inst_valid, 1);
        chk("A_c2_pc", PCout, 32'h8000_0000);
        applyStimulus(1'b0, '0);
        chk("A_c3_pc", PCout, 32'h8000_0004);
        chk("A_hs_count", hsLog.size(), 4);

        // IDU stalled: the FIFO fills after exactly DEPTH requests.
        irMode = MODE_ZERO;
        doReset();
        runIdle(10);
        chk("B_req_count", hsLog.size(), 4);
        chk("B_req_valid_idle", req_valid, 0);
        chk("B_head_pc", PCout, 32'h8000_0000);
        irMode = MODE_ONE;
        runIdle(8);
        chk("B_drain0", dlvLog[0], 32'h8000_0000);
        chk("B_drain1", dlvLog[1], 32'h8000_0004);
        chk("B_drain2", dlvLog[2], 32'h8000_0008);
        chk("B_drain3", dlvLog[3], 32'h8000_000C);
        chk("B_resume_addr", hsLog[4], 32'h8000_0010);

        // Redirect while waiting on a 3-cycle response.
        latMin = 3; latMax = 3;
        doReset();
        applyStimulus(1'b0, '0);
        applyStimulus(1'b1, 32'h8000_1000);
        applyStimulus(1'b0, '0);
        chk("C_flush", inst_valid, 0);
        runIdle(12);
        chk("C_next_req", hsLog[1], 32'h8000_1000);
        chk("C_first_pc", dlvLog[0], 32'h8000_1000);

        // Redirect while a request is held by req_ready=0.
        latMin = 1; latMax = 1;
        doReset();
        runIdle(2);
        rrMode = MODE_ZERO;
        applyStimulus(1'b0, '0);
        chk("D_held_valid", req_valid, 1);
        chk("D_held_addr", req_addr, 32'h8000_0008);
        applyStimulus(1'b1, 32'h8000_2000);
        chk("D_jump_addr_held", req_addr, 32'h8000_0008);
        applyStimulus(1'b0, '0);
        chk("D_after_jump_addr", req_addr, 32'h8000_0008);
        rrMode = MODE_ONE;
        runIdle(9);
        chk("D_old_accepted", hsLog[2], 32'h8000_0008);
        chk("D_next_req", hsLog[3], 32'h8000_2000);
        chk("D_first_pc", dlvLog[2], 32'h8000_2000);

        // Redirect coinciding with a response and a dequeue.
        doReset();
        runIdle(3);
        applyStimulus(1'b1, 32'h8000_3000);
        applyStimulus(1'b0, '0);
        chk("E_flush", inst_valid, 0);
        runIdle(6);
        chk("E_consumed_pc", dlvLog[1], 32'h8000_0004);
        chk("E_next_req", hsLog[3], 32'h8000_3000);
        chk("E_first_pc", dlvLog[2], 32'h8000_3000);

`ifdef IFU_MISALIGN_CHECK_EN
        // Misaligned redirect produces one fault entry and stalls fetch.
        doReset();
        runIdle(3);
        applyStimulus(1'b1, 32'h8000_0002);
        applyStimulus(1'b0, '0);
        chk("F_fault_valid", inst_valid, 1);
        chk("F_fault_bit", inst_fault, 1);
        chk("F_fault_pc", PCout, 32'h8000_0002);
        chk("F_fault_inst", inst_o, 0);
        hsBefore = hsLog.size();
        runIdle(6);
        chk("F_no_request", hsLog.size(), hsBefore);
        chk("F_empty", inst_valid, 0);
        applyStimulus(1'b1, 32'h8000_0100);
        runIdle(6);
        chk("F_resume_req", hsLog[hsBefore], 32'h8000_0100);
`endif

        // Randomized traffic with redirects and occasional resets.
        rrMode = MODE_RAND; latMin = 1; latMax = 3;
        doReset();
        for (int i = 0; i < 4000; i++) begin
            irMode = ((i / 500) % 2 == 1) ? MODE_ONE : MODE_RAND;
            if ($urandom_range(0, 999) == 0) begin
                doReset();
            end else if ($urandom_range(0, 29) == 0) begin
                ja = RESET_PC + ($urandom_range(0, 511) << 2);
`ifdef IFU_MISALIGN_CHECK_EN
                if ($urandom_range(0, 7) == 0) begin
                    ja = ja + $urandom_range(1, 3);
                end
`endif
                applyStimulus(1'b1, ja);
            end else begin
                applyStimulus(1'b0, '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor to the single-cycle instruction fetch stage.
- Fetches instructions over a valid/ready memory request/response interface with variable latency; at most one request in flight.
- Buffers fetched instructions with their PCs in a DEPTH-entry prefetch FIFO.
- Delivers them to the IDU through a valid/ready handshake; a redirect from EXU flushes the FIFO and discards any stale response.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- PC_STEP, 4, PC increment per sequential fetch.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, synchronous active-low reset; state is reset on a posedge clk where rst==0.
- jump_en, input, 1, redirect request from EXU.
- jump_addr, input, ADDR_W, redirect target.
- req_valid, output, 1, fetch request valid.
- req_ready, input, 1, memory accepts request.
- req_addr, output, ADDR_W, fetch address.
- resp_valid, input, 1, memory response valid; always accepted, no backpressure.
- resp_data, input, INST_W, fetched instruction.
- inst_valid, output, 1, FIFO head valid toward IDU.
- inst_ready, input, 1, IDU accepts head.
- inst_o, output, INST_W, head instruction.
- PCout, output, ADDR_W, head PC.
- inst_fault, output, 1, head entry is a misalignment fault (see Optional Feature); constant 0 when the feature is off.

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, state IDLE, drop flag clear. Outputs req_valid=0, inst_valid=0, inst_fault=0. req_addr, inst_o and PCout are don't-care while their valid is low.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when free slots > 0, where free = DEPTH - count.
  - REQ: req_valid=1 and req_addr=fetch_pc, both held stable until req_ready. On handshake: fetch_pc += PC_STEP (wraps modulo 2^ADDR_W), go to WAIT.
  - WAIT: on resp_valid, if drop is clear, enqueue {resp_data, pc_of_request}; if drop is set, discard the response and clear drop. In the same cycle go to REQ if a slot is free after this enqueue and any same-cycle dequeue, otherwise IDLE.
- pc_of_request is captured at the request handshake.
- Slots are reserved at request issue, so the FIFO never overflows. Simultaneous enqueue and dequeue when full is legal; count is unchanged.
- Throughput: with req_ready=1 and a 1-cycle response, a new request issues in the response cycle, giving 1 instruction/cycle. First inst_valid rises 2 cycles after reset release.
- IDU side: inst_valid = !empty. The head pops on inst_valid && inst_ready. inst_o and PCout hold stable while inst_valid && !inst_ready.
- Redirect (jump_en=1) has priority over every other event in the same cycle:
  - FIFO flushed (count=0, pointers reset); inst_valid=0 next cycle.
  - fetch_pc <= jump_addr.
  - In WAIT: drop set, unless resp_valid arrives the same cycle, in which case that response is discarded and drop stays clear.
  - In REQ with the handshake this cycle: the request completes, drop is set, go to WAIT.
  - In REQ without the handshake: req_valid stays high with the old address (no retraction); drop is pre-armed and the eventual response is discarded.
  - After the discarded response, fetching resumes from jump_addr.
- A redirect while drop is already set keeps drop set and updates fetch_pc; only one response is ever discarded.
- A dequeue in the redirect cycle is consumed by the IDU; the flush covers all remaining entries.
- Reset mid-transaction clears all state. The memory is reset on the same rst, so no response from before reset is expected.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- With it:
  - A redirect whose jump_addr is not aligned to PC_STEP issues no memory request. It enqueues one entry {inst=0, PC=jump_addr, fault=1} when a slot is free.
  - Fetch then stalls in IDLE until the next redirect.
  - inst_fault mirrors the head entry's fault bit.
- Without it: no alignment check; fault bits are not stored; inst_fault is tied 0.

Test Plan:
- Reset release, req_ready=1, 1-cycle memory, inst_ready=1 -> req_addr 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; inst_valid from cycle 2 with PCout incrementing by 4 each cycle.
- inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issue, then req_valid=0; FIFO holds PCs 0x80000000..0x8000000C in order; raising inst_ready drains them, then fetching resumes at 0x80000010.
- 3-cycle memory latency, jump_en with jump_addr=0x80001000 in WAIT -> the in-flight response is discarded, the FIFO is empty next cycle, and the next req_addr and first delivered PCout are 0x80001000.
- req_ready=0 holding a request at 0x80000008 when jump_en asserts to 0x80002000 -> req_addr stays 0x80000008 until accepted; its response is dropped; the next request is 0x80002000.
- jump_en coinciding with resp_valid and with inst_valid&&inst_ready -> the response is not enqueued, drop is not set, and the next PCout is jump_addr.
- IFU_MISALIGN_CHECK_EN defined, jump_addr=0x80000002 -> no request issued; one entry with inst_fault=1 and PCout=0x80000002; a subsequent jump_en to 0x80000100 resumes normal fetch.
